// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the five-stage pipeline controller and the ALU stage:
//   - opcode constants for the 4-bit op field
//   - bit positions of the instruction fields (op/rd/rs/rt slices)
//   - controller FSM state encoding
// Instruction layout: op [15:12], rd [11:8], rs [7:4], rt [3:0].
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int IR_W    = 16;
    localparam int NSTAGE  = 5;

    // Field slice positions: use as ir[<FIELD>_MSB -: <field width>].
    localparam int OP_MSB  = 15;
    localparam int RD_MSB  = 11;
    localparam int RS_MSB  = 7;
    localparam int RT_MSB  = 3;

    // Opcodes
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SHL   = 4'h5;
    localparam logic [3:0] OP_SHR   = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JUMP  = 4'hC;
    localparam logic [3:0] OP_NOP   = 4'hF;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STALLED = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// ---------------------------------------------------------------------------
// hazard_det
// Combinational load-use hazard detector.
// Ports:
//   IR_ID  [15:0]  instruction in decode (sources rs, rt are examined)
//   IR_EX  [15:0]  instruction in the ALU stage (op and rd are examined)
//   STAGEV [2:1]   valid bits of EX (bit 2) and ID (bit 1)
//   HAZ            high when a valid LOAD in EX writes a register that the
//                  valid instruction in ID reads
// ---------------------------------------------------------------------------
module hazard_det
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int REGW = 4
) (
    input  logic [15:0] IR_ID,
    input  logic [15:0] IR_EX,
    input  logic [2:1]  STAGEV,
    output logic        HAZ
);

    logic [OPW-1:0]  op_ex;
    logic [REGW-1:0] rd_ex;
    logic [REGW-1:0] rs_id;
    logic [REGW-1:0] rt_id;
    logic            unused_fields;

    assign op_ex = IR_EX[OP_MSB -: OPW];
    assign rd_ex = IR_EX[RD_MSB -: REGW];
    assign rs_id = IR_ID[RS_MSB -: REGW];
    assign rt_id = IR_ID[RT_MSB -: REGW];

    // Decode op/rd and the EX source fields play no part in a load-use check.
    assign unused_fields = ^{IR_ID[15:8], IR_EX[7:0]};

    assign HAZ = STAGEV[2] & STAGEV[1]
               & (op_ex == OPW'(OP_LOAD))
               & ((rd_ex == rs_id) | (rd_ex == rt_id));

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Control FSM for a five-stage IF/ID/EX/MEM/WB pipeline.
// Ports:
//   CLK, RST              clock; asynchronous active-high reset
//   START                 level, begins fetching when sampled high in IDLE
//   HALT                  level, stops fetch and drains the pipeline
//   IR_ID, IR_EX  [15:0]  instructions currently in decode and in EX
//   STAGEV        [4:0]   per-stage valids (bit0 IF .. bit4 WB), registered
//   PC_WE                 PC write enable (combinational)
//   PC_SEL                1 = jump target from EX, 0 = PC+1 (combinational)
//   IFID_WE               IF/ID register write enable, registered
//   STALL                 high during the load-use bubble cycle (combinational)
//   DONE                  one-cycle pulse when a drain completes, registered
//   STALL_CNT  [CNTW-1:0] bubble cycles since the last START, saturating
//   DBG_STATE             current FSM state, for observation only
//
// Stage-valid behaviour:
//   RUN      valids shift toward WB each edge with a new fetch entering IF.
//   hazard   (RUN only) EX becomes a bubble, IF/ID hold, MEM/WB advance,
//            and the FSM spends exactly one cycle in STALLED, where the PC
//            and IF/ID are frozen and STALL is high.
//   jump     valids shift but IF and ID are both cleared; the PC loads the
//            target. Wins over a coincident hazard.
//   DRAIN    valids shift with nothing fetched; a jump here flushes but
//            never writes the PC. Once all valids are zero, the next edge
//            returns to IDLE and pulses DONE.
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int REGW = 4,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            HALT,
    input  logic [15:0]     IR_ID,
    input  logic [15:0]     IR_EX,
    output logic [4:0]      STAGEV,
    output logic            PC_WE,
    output logic            PC_SEL,
    output logic            IFID_WE,
    output logic            STALL,
    output logic            DONE,
    output logic [CNTW-1:0] STALL_CNT,
    output state_e          DBG_STATE
);

    state_e          state_q, state_d;
    logic [4:0]      stagev_q, stagev_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            ifid_we_q;

    logic            haz;
    logic            is_jump;
    logic            fetching;

    hazard_det #(
        .OPW  (OPW),
        .REGW (REGW)
    ) u_hazard_det (
        .IR_ID  (IR_ID),
        .IR_EX  (IR_EX),
        .STAGEV (stagev_q[2:1]),
        .HAZ    (haz)
    );

    assign is_jump  = stagev_q[2] & (IR_EX[OP_MSB -: OPW] == OPW'(OP_JUMP));
    assign fetching = (state_q == ST_RUN) | (state_q == ST_STALLED);

    // PC control is decoded from the current state so that reset forces it
    // low at once; a jump in DRAIN is deliberately excluded via 'fetching'.
    assign PC_SEL = fetching & is_jump;
    assign PC_WE  = (state_q == ST_RUN) | PC_SEL;
    assign STALL  = (state_q == ST_STALLED);

    always_comb begin
        state_d  = state_q;
        stagev_d = stagev_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START && !HALT) begin
                    state_d  = ST_RUN;
                    stagev_d = 5'b00001;
                    cnt_d    = '0;
                end
            end
            ST_RUN, ST_STALLED: begin
                // The bubble cycle is counted as STALLED is left, whatever
                // the exit (RUN or DRAIN).
                if ((state_q == ST_STALLED) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                if (HALT) begin
                    state_d  = ST_DRAIN;
                    stagev_d = {stagev_q[3:1], stagev_q[0] & ~is_jump, 1'b0};
                end else if (is_jump) begin
                    state_d  = ST_RUN;
                    stagev_d = {stagev_q[3:1], 2'b00};
                end else if (haz && (state_q == ST_RUN)) begin
                    // Bubble into EX; IF and ID keep their valids.
                    state_d  = ST_STALLED;
                    stagev_d = {stagev_q[3:2], 1'b0, stagev_q[1:0]};
                end else begin
                    state_d  = ST_RUN;
                    stagev_d = {stagev_q[3:0], 1'b1};
                end
            end
            ST_DRAIN: begin
                if (stagev_q == 5'b00000) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    stagev_d = {stagev_q[3:1], stagev_q[0] & ~is_jump, 1'b0};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            stagev_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ifid_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stagev_q  <= stagev_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            ifid_we_q <= (state_d == ST_RUN);
        end
    end

    assign STAGEV    = stagev_q;
    assign STALL_CNT = cnt_q;
    assign DONE      = done_q;
    assign IFID_WE   = ifid_we_q;
    assign DBG_STATE = state_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter OPW, default 4, opcode field width in bits.
REQ-002 Parameter REGW, default 4, register-specifier field width in bits.
REQ-003 Parameter CNTW, default 16, stall-counter width in bits.
REQ-004 CLK  input  1  Single clock; all state updates on posedge CLK.
REQ-005 RST  input  1  Reset, asynchronous and active-high.
REQ-006 START  input  1  Level; begins fetching when sampled high in IDLE.
REQ-007 HALT  input  1  Level; stops fetch and drains the pipeline.
REQ-008 IR_ID  input  16  Instruction in decode: op [15:12], rd [11:8], rs [7:4], rt [3:0].
REQ-009 IR_EX  input  16  Instruction in the ALU stage, same field layout.
REQ-010 STAGEV  output  5  Per-stage valid, driven to datapath stage enables: bit0 IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB.
REQ-011 PC_WE  output  1  PC register write enable.
REQ-012 PC_SEL  output  1  1 selects the jump target from EX; 0 selects PC+1.
REQ-013 IFID_WE  output  1  IF/ID pipeline register write enable.
REQ-014 STALL  output  1  High during a load-use bubble cycle.
REQ-015 DONE  output  1  One-cycle pulse when the drain completes.
REQ-016 STALL_CNT  output  CNTW  Number of bubble cycles since the last START.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, STALLED, DRAIN.
REQ-018 IDLE: STAGEV=0, PC_WE=0, IFID_WE=0; START=1 SHALL go to RUN and clear STALL_CNT.
REQ-019 RUN: STAGEV[0] SHALL be 1 each cycle; STAGEV[4:1] SHALL shift from STAGEV[3:0] each posedge; PC_WE=1; IFID_WE=1.
REQ-020 Load-use hazard SHALL be declared when all of the following hold: STAGEV[2]=1, IR_EX op=LOAD, STAGEV[1]=1, and IR_EX rd equals IR_ID rs or IR_ID rt.
REQ-021 Hazard in RUN SHALL go to STALLED for exactly one cycle: PC_WE=0, IFID_WE=0, STALL=1; EX valid is cleared (bubble) on the next edge; IF and ID valids hold.
REQ-022 STALLED SHALL return to RUN unconditionally and increment STALL_CNT by 1, saturating at all-ones.
REQ-023 Jump (STAGEV[2]=1 and IR_EX op=JUMP) SHALL assert PC_SEL=1 and PC_WE=1 combinationally and clear STAGEV[1:0] on the next edge.
REQ-024 Jump SHALL take priority over a simultaneous load-use hazard; no stall is counted in that case.
REQ-025 HALT=1 in RUN or STALLED SHALL go to DRAIN: STAGEV[0]=0, PC_WE=0, IFID_WE=0; in-flight valids keep shifting.
REQ-026 A jump seen in DRAIN SHALL NOT write the PC.
REQ-027 DRAIN SHALL go to IDLE and pulse DONE for one cycle on the edge where STAGEV[4:0]=0.
REQ-028 START and HALT both high in IDLE SHALL leave the FSM in IDLE.
REQ-029 Reaching DRAIN SHALL take at most 5 cycles after HALT; DONE SHALL fire at most 5 cycles after entering DRAIN.
REQ-030 All outputs except PC_SEL, PC_WE and STALL SHALL be registered.

Reset
REQ-031 RST=1 SHALL immediately force IDLE, STAGEV=0, STALL_CNT=0, DONE=0, PC_WE=0, PC_SEL=0, IFID_WE=0, STALL=0, including mid-stall or mid-drain.
REQ-032 Release of RST SHALL take effect at the next posedge CLK, and no output SHALL toggle before that edge.

Structure
REQ-033 Opcode constants (LOAD, JUMP, ADD, ...), the field-slice macros and the FSM state encodings SHALL live in the shared definitions file used by the ALU stage.
REQ-034 Hazard detection SHALL be one combinational sub-module, hazard_det, with inputs IR_ID, IR_EX and STAGEV[2:1], and output HAZ.

Verification
REQ-035 Reset, START pulse, 6 ALU ops: STAGEV SHALL reach 5'b11111 on the 5th edge after START; PC_WE=1 throughout.
REQ-036 Load-use: EX=LOAD rd=3, ID=ADD rs=3: STALL=1 for one cycle, PC_WE=0, EX bubble, STALL_CNT=1.
REQ-037 Load-use with rd=3 matching rt=3 while EX=JUMP fires in the same cycle: PC_SEL=1, STAGEV[1:0]=0 next cycle, STALL_CNT unchanged.
REQ-038 HALT in RUN with a full pipeline: STAGEV[0]=0 next cycle; DONE pulses exactly 5 edges later; FSM returns to IDLE.
REQ-039 Assert RST during STALLED: all outputs zero immediately; after release, no activity until START.
REQ-040 Force 2^CNTW hazards: STALL_CNT SHALL saturate at 16'hFFFF.
